// File: rtl/echo_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : echo_arbiter_pkg
// Purpose  : Shared definitions for the echo arbiter: default payload width,
//            client identifier type and its values, and width helpers for
//            the tag-queue pointers and occupancy counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package echo_arbiter_pkg;

  localparam int WIDTH_DEFAULT = 96;

  typedef logic client_t;

  localparam client_t CLIENT0 = 1'b0;
  localparam client_t CLIENT1 = 1'b1;

  // Pointer width for a ring of 'depth' entries (at least one bit).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Counter width able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : echo_arbiter_pkg
`default_nettype wire

// File: rtl/echo_arbiter_tagq.sv
`default_nettype none
// ============================================================================
// Module   : echo_arbiter_tagq
// Purpose  : Ring of 1-bit client tags recording which client owns each word
//            currently held in the echo FIFO, in FIFO order.
// Ports    : CLK, nRST      - clock, asynchronous active-low reset
//            push, push_tag - append a tag at the write pointer
//            pop            - retire the tag at the read pointer
//            head           - tag at the read pointer
//            count          - number of valid tags (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module echo_arbiter_tagq
  import echo_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         push,
  input  client_t                      push_tag,
  input  logic                         pop,
  output client_t                      head,
  output logic [cnt_width(DEPTH)-1:0]  count
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [DEPTH-1:0] ring_q, ring_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    ring_d  = ring_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;

    if (push) begin
      ring_d[wptr_q] = push_tag;
      wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    end

    if (pop) begin
      rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    end

    // Simultaneous push and pop leaves occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ring_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      ring_q  <= ring_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head  = ring_q[rptr_q];
  assign count = count_q;

endmodule : echo_arbiter_tagq
`default_nettype wire

// File: rtl/echo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : echo_arbiter
// Purpose  : Two-client front end for the shared echo FIFO. Alternates an
//            enqueue slot between two 'say' channels, tags every enqueued
//            word with its client, and steers each word leaving the FIFO to
//            the originating client's 'heard' indication.
// Ports    : CLK, nRST                 - clock, async active-low reset
//            req{0,1}_say__*          - client requests (ENA/v in, RDY out)
//            fifo_enq__*              - FIFO enqueue port
//            fifo_out_*               - FIFO head / dequeue port
//            ind{0,1}_heard__*        - client indications (ENA/v out, RDY in)
// Revision : 1.0 - initial release
// ============================================================================
module echo_arbiter
  import echo_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             nRST,

  input  logic             req0_say__ENA,
  input  logic [WIDTH-1:0] req0_say_v,
  output logic             req0_say__RDY,
  input  logic             req1_say__ENA,
  input  logic [WIDTH-1:0] req1_say_v,
  output logic             req1_say__RDY,

  output logic             fifo_enq__ENA,
  output logic [WIDTH-1:0] fifo_enq_v,
  input  logic             fifo_enq__RDY,

  input  logic [WIDTH-1:0] fifo_out_first,
  input  logic             fifo_out_first__RDY,
  input  logic             fifo_out_deq__RDY,
  output logic             fifo_out_deq__ENA,

  output logic             ind0_heard__ENA,
  output logic [WIDTH-1:0] ind0_heard_v,
  input  logic             ind0_heard__RDY,
  output logic             ind1_heard__ENA,
  output logic [WIDTH-1:0] ind1_heard_v,
  input  logic             ind1_heard__RDY
);

  localparam int CNT_W = cnt_width(DEPTH);

  client_t          slot_q, slot_d;
  client_t          head;
  logic [CNT_W-1:0] count;
  logic             space;
  logic             avail;
  logic             push;
  logic             pop;

  // Grants depend only on registered state and the FIFO's own readiness,
  // never on client strobes.
  assign space         = fifo_enq__RDY & (count != CNT_W'(DEPTH));
  assign req0_say__RDY = space & (slot_q == CLIENT0);
  assign req1_say__RDY = space & (slot_q == CLIENT1);

  assign push          = req0_say__ENA | req1_say__ENA;
  assign fifo_enq__ENA = push;
  assign fifo_enq_v    = (slot_q == CLIENT1) ? req1_say_v : req0_say_v;

  // The slot advances on every available cycle, used or not, so each client
  // sees every other available cycle.
  always_comb begin
    slot_d = slot_q;
    if (space) begin
      slot_d = ~slot_q;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      slot_q <= CLIENT0;
    end else begin
      slot_q <= slot_d;
    end
  end

  // Only the head tag's client may take the word; a stalled head blocks the
  // other client to keep FIFO order. No tag means no routing.
  assign avail           = (count != '0) & fifo_out_first__RDY & fifo_out_deq__RDY;
  assign ind0_heard__ENA = avail & (head == CLIENT0) & ind0_heard__RDY;
  assign ind1_heard__ENA = avail & (head == CLIENT1) & ind1_heard__RDY;
  assign pop             = ind0_heard__ENA | ind1_heard__ENA;
  assign fifo_out_deq__ENA = pop;
  assign ind0_heard_v    = fifo_out_first;
  assign ind1_heard_v    = fifo_out_first;

  echo_arbiter_tagq #(
    .DEPTH (DEPTH)
  ) u_tagq (
    .CLK      (CLK),
    .nRST     (nRST),
    .push     (push),
    .push_tag (slot_q),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

endmodule : echo_arbiter
`default_nettype wire
